wavebank_arb: RTL and testbench



---
 rtl/wavebank_arb.sv | 104 ++++++++++
 tb/tb_wavebank_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wavebank_arb.sv
// Multi-bank wavetable sample memory with a round-robin arbitrated read port
// shared by several oscillator channels. Reads return two cycles after grant.
module wavebank_arb #(
  parameter  int DATAWIDTH = 16,
  parameter  int ADDRWIDTH = 8,
  parameter  int NUM_BANKS = 4,
  parameter  int NUM_CH    = 3,
  localparam int BW        = $clog2(NUM_BANKS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [BW-1:0]                 wr_bank,
  input  logic [ADDRWIDTH-1:0]          wr_addr,
  input  logic [DATAWIDTH-1:0]          wr_data,
  output logic                          wr_err,
  input  logic [NUM_CH-1:0]             rd_req,
  input  logic [NUM_CH*BW-1:0]          rd_bank,
  input  logic [NUM_CH*ADDRWIDTH-1:0]   rd_addr,
  output logic [NUM_CH-1:0]             rd_ack,
  output logic [NUM_CH*DATAWIDTH-1:0]   rd_data
);

  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [BW:0] NB_L = (BW+1)'(NUM_BANKS);

  function automatic logic bank_ok(input logic [BW-1:0] b);
    return {1'b0, b} < NB_L;
  endfunction

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] c);
    if (int'(c) == NUM_CH - 1) return '0;
    return c + 1'b1;
  endfunction

  logic [DATAWIDTH-1:0] mem [NUM_BANKS][DEPTH];

  logic [CW-1:0]        rr_ptr;
  logic [NUM_CH-1:0]    busy;
  logic [NUM_CH-1:0]    elig;
  logic                 gnt_vld_p0;
  logic [CW-1:0]        gnt_ch_p0;
  logic [BW-1:0]        gnt_bank_p0;
  logic [ADDRWIDTH-1:0] gnt_addr_p0;
  logic                 vld_p1;
  logic [CW-1:0]        ch_p1;
  logic [DATAWIDTH-1:0] word_p1;
  int                   idx;

  // p0: round-robin grant; a channel stays ineligible while its read sits in p1
  always_comb begin
    busy       = '0;
    gnt_vld_p0 = 1'b0;
    gnt_ch_p0  = '0;
    idx        = 0;
    if (vld_p1) busy[ch_p1] = 1'b1;
    elig = rd_req & ~busy;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_vld_p0 && elig[idx]) begin
        gnt_vld_p0 = 1'b1;
        gnt_ch_p0  = CW'(idx);
      end
    end
  end

  assign gnt_bank_p0 = rd_bank[int'(gnt_ch_p0)*BW +: BW];
  assign gnt_addr_p0 = rd_addr[int'(gnt_ch_p0)*ADDRWIDTH +: ADDRWIDTH];

  // p0 -> p1: array write and bank-muxed read; read sees the pre-write word
  always_ff @(posedge clk) begin
    if (wr_valid && !rst && bank_ok(wr_bank))
      mem[wr_bank][wr_addr] <= wr_data;
    if (gnt_vld_p0)
      word_p1 <= bank_ok(gnt_bank_p0) ? mem[gnt_bank_p0][gnt_addr_p0] : '0;
  end

  // p1 -> p2: deliver word to the owning channel with a one-cycle ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      vld_p1  <= 1'b0;
      ch_p1   <= '0;
      rd_ack  <= '0;
      rd_data <= '0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= wr_valid && !bank_ok(wr_bank);
      vld_p1 <= gnt_vld_p0;
      if (gnt_vld_p0) begin
        ch_p1  <= gnt_ch_p0;
        rr_ptr <= wrap_inc(gnt_ch_p0);
      end
      rd_ack <= '0;
      if (vld_p1) begin
        rd_ack[ch_p1] <= 1'b1;
        rd_data[int'(ch_p1)*DATAWIDTH +: DATAWIDTH] <= word_p1;
      end
    end
  end

endmodule

// File: tb/tb_wavebank_arb.sv
// Bench for wavebank_arb: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_wavebank_arb;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NB = 3;
  localparam int NC = 3;
  localparam int BW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic [BW-1:0]     wr_bank;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              wr_err;
  logic [NC-1:0]     rd_req;
  logic [NC*BW-1:0]  rd_bank;
  logic [NC*AW-1:0]  rd_addr;
  logic [NC-1:0]     rd_ack;
  logic [NC*DW-1:0]  rd_data;

  always #5 clk = ~clk;

  wavebank_arb #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .NUM_BANKS(NB), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err),
    .rd_req(rd_req), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data)
  );

  // reference model state
  typedef struct { int ch; int due; logic [DW-1:0] d; } rd_t;
  rd_t              pend[$];
  logic [DW-1:0]    mmem [NB][256];
  logic [DW-1:0]    exp_data [NC];
  int               gnt_cyc [NC];
  int               last_gnt;
  int               cyc;
  logic [NC-1:0]    ack_log [int];
  int               nchk = 0;
  int               nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    for (int c = 0; c < NC; c++) begin
      exp_data[c] = '0;
      gnt_cyc[c]  = -10;
    end
    last_gnt = NC - 1;
  endtask

  // one clock: model the cycle from current inputs, advance, compare outputs
  task automatic step();
    int g;
    int b;
    int c;
    rd_t r;
    logic err_exp;
    logic [NC-1:0] ack_exp;
    g = -1;
    err_exp = 1'b0;
    if (rst) model_clear();
    else begin
      for (int i = 1; i <= NC; i++) begin
        c = (last_gnt + i) % NC;
        if (g < 0 && rd_req[c] && gnt_cyc[c] != cyc - 1) g = c;
      end
      if (g >= 0) begin
        b = int'(rd_bank[g*BW +: BW]);
        r.ch  = g;
        r.due = cyc + 2;
        r.d   = (b < NB) ? mmem[b][rd_addr[g*AW +: AW]] : '0;
        pend.push_back(r);
        last_gnt   = g;
        gnt_cyc[g] = cyc;
      end
      if (wr_valid) begin
        if (int'(wr_bank) < NB) mmem[wr_bank][wr_addr] = wr_data;
        else err_exp = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    ack_exp = '0;
    for (int k = pend.size() - 1; k >= 0; k--) begin
      if (pend[k].due == cyc) begin
        ack_exp[pend[k].ch]  = 1'b1;
        exp_data[pend[k].ch] = pend[k].d;
        pend.delete(k);
      end
    end
    ack_log[cyc] = rd_ack;
    chk("rd_ack", rd_ack, ack_exp);
    for (int n = 0; n < NC; n++)
      chk($sformatf("rd_data%0d", n), rd_data[n*DW +: DW], exp_data[n]);
    chk("wr_err", wr_err, err_exp);
  endtask

  initial begin
    int t0;
    logic [DW-1:0] d0;
    logic [DW-1:0] d2;
    int acks;
    rst = 1'b1; wr_valid = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    rd_req = '0; rd_bank = '0; rd_addr = '0;
    cyc = 0;
    model_clear();
    step(); step();
    chk("reset_rd_data", rd_data, '0);
    chk("reset_rd_ack", rd_ack, '0);
    rst = 1'b0;

    // prefill the region read later
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 8; a++) begin
        wr_valid = 1'b1; wr_bank = BW'(b); wr_addr = AW'(a); wr_data = DW'($urandom);
        step();
      end
    wr_bank = 2'd2; wr_addr = 8'h10; wr_data = 16'hBEEF; step();
    wr_bank = 2'd1; wr_addr = 8'h05; wr_data = 16'hAAAA; step();
    wr_valid = 1'b0;

    // single read, ack two cycles after grant
    rd_req = 3'b001; rd_bank[1:0] = 2'd2; rd_addr[7:0] = 8'h10;
    step();
    rd_req = '0;
    step();
    chk("r035_ack", rd_ack, 3'b001);
    chk("r035_data", rd_data[15:0], 16'hBEEF);
    step();

    // all three request together after reset
    rst = 1'b1; step(); rst = 1'b0;
    rd_req = 3'b111; rd_bank = {2'd0, 2'd0, 2'd0}; rd_addr = {8'd3, 8'd2, 8'd1};
    t0 = cyc;
    repeat (6) step();
    rd_req = '0;
    step(); step();
    chk("r036_ack_t2", ack_log[t0+2], 3'b001);
    chk("r036_ack_t3", ack_log[t0+3], 3'b010);
    chk("r036_ack_t4", ack_log[t0+4], 3'b100);
    chk("r036_ack_t5", ack_log[t0+5], 3'b001);

    // same-cycle write and read of one word
    rd_req = 3'b010; rd_bank[3:2] = 2'd1; rd_addr[15:8] = 8'd5;
    wr_valid = 1'b1; wr_bank = 2'd1; wr_addr = 8'd5; wr_data = 16'h1234;
    step();
    wr_valid = 1'b0; rd_req = '0;
    step();
    chk("r037_old", rd_data[31:16], 16'hAAAA);
    rd_req = 3'b010;
    step();
    rd_req = '0;
    step();
    chk("r037_new", rd_data[31:16], 16'h1234);

    // out-of-range bank write and read
    wr_valid = 1'b1; wr_bank = 2'd3; wr_addr = 8'd5; wr_data = 16'h5555;
    step();
    chk("r038_err", wr_err, 1'b1);
    wr_valid = 1'b0;
    step();
    chk("r038_err_clr", wr_err, 1'b0);
    rd_req = 3'b101; rd_bank = {2'd3, 2'd0, 2'd1}; rd_addr = {8'd5, 8'd0, 8'd5};
    t0 = cyc;
    step(); step();
    rd_req = '0;
    step(); step();
    chk("r038_oob_ack", ack_log[t0+2], 3'b100);
    chk("r038_oob_data", rd_data[47:32], 16'h0000);
    chk("r038_keep", rd_data[15:0], 16'h1234);

    // reset while a read is in flight
    rd_req = 3'b100; rd_bank[5:4] = 2'd0; rd_addr[23:16] = 8'd4;
    t0 = cyc;
    step();
    rd_req = '0; rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step();
    chk("r039_noack", ack_log[t0+2], 3'b000);
    chk("r039_data", rd_data, '0);
    rd_req = 3'b110; rd_addr[15:8] = 8'd6; rd_bank[3:2] = 2'd0;
    t0 = cyc;
    step(); step();
    rd_req = '0;
    step(); step();
    chk("r039_first", ack_log[t0+2], 3'b010);
    chk("r039_second", ack_log[t0+3], 3'b100);

    // single channel streams at one grant per two cycles
    d0 = exp_data[0]; d2 = exp_data[2];
    rd_req = 3'b010; rd_bank[3:2] = 2'd2; rd_addr[15:8] = 8'd7;
    t0 = cyc;
    repeat (10) step();
    rd_req = '0;
    step(); step();
    acks = 0;
    for (int k = 1; k <= 12; k++) if (ack_log[t0+k][1]) acks++;
    chk("r040_ack_count", acks, 5);
    for (int k = 2; k <= 5; k++)
      chk($sformatf("r040_ack_t%0d", k), ack_log[t0+k], (k % 2 == 0) ? 3'b010 : 3'b000);
    chk("r040_ch0_hold", rd_data[15:0], d0);
    chk("r040_ch2_hold", rd_data[47:32], d2);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      rd_req = NC'($urandom);
      for (int c = 0; c < NC; c++) begin
        rd_bank[c*BW +: BW] = BW'($urandom_range(0, 3));
        rd_addr[c*AW +: AW] = AW'($urandom_range(0, 7));
      end
      wr_valid = $urandom_range(0, 1) == 1;
      wr_bank  = BW'($urandom_range(0, 3));
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = DW'($urandom);
      step();
    end
    rst = 1'b0; rd_req = '0; wr_valid = 1'b0;
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
